// File: rtl/nn_sched_pkg.sv
// -----------------------------------------------------------------------------
// nn_sched_pkg
// Shared definitions for the inference scheduler slice:
//   - sched_state_t : scheduler FSM states (IDLE / LOAD / WAIT / RESULT)
//   - count_width / timer_width : width helpers so that the beat counter can
//     hold NUM_INPUTS and the watchdog timer can hold TIMEOUT_CYCLES
//   - COUNT_W / TIMER_W : widths for the default parameterisation
// Optional feature macro used elsewhere in the slice: NN_SCHED_PERF_EN
// -----------------------------------------------------------------------------
package nn_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } sched_state_t;

    localparam int DEFAULT_NUM_INPUTS     = 784;
    localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

    // Enough bits to represent the value n itself (not just 0..n-1).
    function automatic int count_width(input int num_inputs);
        return $clog2(num_inputs + 1);
    endfunction

    function automatic int timer_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

    localparam int COUNT_W = $clog2(DEFAULT_NUM_INPUTS + 1);
    localparam int TIMER_W = $clog2(DEFAULT_TIMEOUT_CYCLES + 1);

endpackage

// File: rtl/nn_infer_sched_if.sv
// -----------------------------------------------------------------------------
// nn_infer_sched_if
// Host-side bundle of the inference scheduler: the framed input stream
// (valid/ready with last) and the result port (valid/ready).
//   s_data/s_valid/s_last : input sample stream, driven by the host (master)
//   s_ready               : scheduler can accept a sample (driven by slave)
//   m_class/m_valid       : captured class result (driven by slave)
//   m_ready               : result consumer ready (driven by master)
// Modports:
//   master : the host / DMA side
//   slave  : the scheduler side
// -----------------------------------------------------------------------------
interface nn_infer_sched_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int CLASS_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0]  s_data;
    logic                   s_valid;
    logic                   s_last;
    logic                   s_ready;
    logic [CLASS_WIDTH-1:0] m_class;
    logic                   m_valid;
    logic                   m_ready;

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_class, m_valid
    );

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_class, m_valid
    );

endinterface

// File: rtl/nn_sched_watchdog.sv
// -----------------------------------------------------------------------------
// nn_sched_watchdog
// Saturating watchdog timer for the scheduler WAIT state.
// Ports:
//   aclk, reset : clock, synchronous active-high reset
//   clear       : force the timer back to zero (used outside WAIT)
//   enable      : count one cycle
//   expired     : asserted in the cycle whose increment makes the timer
//                 reach TIMEOUT_CYCLES, i.e. the TIMEOUT_CYCLES-th enabled
//                 cycle after a clear
// -----------------------------------------------------------------------------
module nn_sched_watchdog
    import nn_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic aclk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = timer_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] timer;

    // Timer saturates at LIMIT instead of wrapping, so a stalled enable
    // can never produce a second, spurious expiry.
    always_ff @(posedge aclk) begin
        if (reset || clear) begin
            timer <= '0;
        end else if (enable && (timer != LIMIT)) begin
            timer <= timer + TW'(1);
        end
    end

    // Expiry is flagged one cycle early so that the owner leaves WAIT on the
    // very edge at which the timer reaches LIMIT.
    assign expired = enable && (timer == (LIMIT - TW'(1)));

endmodule

// File: rtl/nn_infer_sched.sv
// -----------------------------------------------------------------------------
// nn_infer_sched
// Inference scheduler owning one complete inference transaction: accepts
// exactly NUM_INPUTS samples from a valid/ready stream, forwards them to
// layer 1 as a valid-only stream (one cycle latency), waits for the
// max-finder result (guarded by a watchdog) and presents the class on a
// valid/ready result port.
// Ports:
//   aclk, reset           : clock, synchronous active-high reset
//   host (slave modport)  : s_data/s_valid/s_last/s_ready input stream,
//                           m_class/m_valid/m_ready result port
//   nn_data, nn_valid     : sample stream to layer 1
//   nn_result(_valid)     : max-finder output
//   busy                  : high whenever not IDLE
//   err_frame             : pulse, s_last misplaced on the previous beat
//   err_timeout           : pulse, watchdog expired while waiting
// Optional (macro NN_SCHED_PERF_EN):
//   perf_latency          : cycles from first accepted beat to result capture
//   perf_frames           : count of delivered results (wraps)
// -----------------------------------------------------------------------------
module nn_infer_sched
    import nn_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_INPUTS     = 784,
    parameter int CLASS_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   aclk,
    input  logic                   reset,
    nn_infer_sched_if.slave        host,
    output logic [DATA_WIDTH-1:0]  nn_data,
    output logic                   nn_valid,
    input  logic [CLASS_WIDTH-1:0] nn_result,
    input  logic                   nn_result_valid,
    output logic                   busy,
    output logic                   err_frame,
    output logic                   err_timeout
`ifdef NN_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_latency,
    output logic [31:0]            perf_frames
`endif
);

    localparam int CW = count_width(NUM_INPUTS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_INPUTS);

    sched_state_t           state;
    sched_state_t           state_next;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic [CW-1:0]          beat_num;
    logic                   is_final;
    logic [DATA_WIDTH-1:0]  nn_data_next;
    logic                   nn_valid_next;
    logic [CLASS_WIDTH-1:0] m_class_r;
    logic [CLASS_WIDTH-1:0] m_class_next;
    logic                   m_valid_r;
    logic                   m_valid_next;
    logic                   err_frame_next;
    logic                   err_timeout_next;
    logic                   accept;
    logic                   capture;
    logic                   deliver;
    logic                   expired;

    // Input is only open while a frame is being collected; the result slot
    // is single-entry, so RESULT keeps the stream closed as well.
    assign host.s_ready = (state == IDLE) || (state == LOAD);
    assign busy         = (state != IDLE);
    assign accept       = host.s_valid && host.s_ready;
    assign capture      = (state == WAIT) && nn_result_valid;
    assign deliver      = (state == RESULT) && m_valid_r && host.m_ready;
    assign host.m_class = m_class_r;
    assign host.m_valid = m_valid_r;

    nn_sched_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .aclk    (aclk),
        .reset   (reset),
        .clear   (state != WAIT),
        .enable  (state == WAIT),
        .expired (expired)
    );

    // State and output registers. Everything visible to the outside is
    // registered so layer 1 sees a clean one-cycle-latency stream.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            nn_data     <= '0;
            nn_valid    <= 1'b0;
            m_class_r   <= '0;
            m_valid_r   <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            nn_data     <= nn_data_next;
            nn_valid    <= nn_valid_next;
            m_class_r   <= m_class_next;
            m_valid_r   <= m_valid_next;
            err_frame   <= err_frame_next;
            err_timeout <= err_timeout_next;
        end
    end

    // Next-state and next-output logic. Only the beat count decides when the
    // frame ends; s_last is checked against it purely for error reporting.
    always_comb begin
        state_next       = state;
        count_next       = count;
        nn_data_next     = nn_data;
        nn_valid_next    = 1'b0;
        m_class_next     = m_class_r;
        m_valid_next     = m_valid_r;
        err_frame_next   = 1'b0;
        err_timeout_next = 1'b0;

        beat_num = (state == IDLE) ? CW'(1) : (count + CW'(1));
        is_final = (beat_num == LAST_BEAT);

        if (accept) begin
            nn_data_next   = host.s_data;
            nn_valid_next  = 1'b1;
            count_next     = beat_num;
            err_frame_next = (host.s_last != is_final);
        end

        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    state_next = is_final ? WAIT : LOAD;
                end
            end
            WAIT: begin
                // A result arriving in the expiry cycle still wins.
                if (nn_result_valid) begin
                    m_class_next = nn_result;
                    m_valid_next = 1'b1;
                    count_next   = '0;
                    state_next   = RESULT;
                end else if (expired) begin
                    err_timeout_next = 1'b1;
                    count_next       = '0;
                    state_next       = IDLE;
                end
            end
            RESULT: begin
                if (m_valid_r && host.m_ready) begin
                    m_valid_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef NN_SCHED_PERF_EN
    logic [31:0] lat_run;

    // lat_run is set to 1 on the first accepted beat and counts every later
    // busy cycle, so at the capture edge it equals the edge distance from the
    // first accept. A timed-out transaction never reaches the capture branch.
    always_ff @(posedge aclk) begin
        if (reset) begin
            lat_run      <= '0;
            perf_latency <= '0;
            perf_frames  <= '0;
        end else begin
            if (accept && (state == IDLE)) begin
                lat_run <= 32'd1;
            end else if (busy) begin
                lat_run <= lat_run + 32'd1;
            end
            if (capture) begin
                perf_latency <= lat_run;
            end
            if (deliver) begin
                perf_frames <= perf_frames + 32'd1;
            end
        end
    end
`else
    // Without performance counters the capture/deliver strobes only feed
    // the FSM; keep them referenced so the default build stays tidy.
    logic unused_strobes;
    assign unused_strobes = capture ^ deliver;
`endif

endmodule

// File: tb/tb_nn_infer_sched.sv
// -----------------------------------------------------------------------------
// tb_nn_infer_sched
// Scoreboard bench for nn_infer_sched (NUM_INPUTS=4, TIMEOUT_CYCLES=20).
// Stimulus tasks drive transactions and push expected events (forwarded
// samples, frame errors, timeouts, results, each with the cycle it must
// appear in) into queues; a monitor on the falling edge pops and compares
// whenever the DUT presents one of those events.
// -----------------------------------------------------------------------------
module tb_nn_infer_sched;

    localparam int DW = 16;
    localparam int NI = 4;
    localparam int CW = 32;
    localparam int TO = 20;

    logic          aclk = 1'b0;
    logic          reset;
    logic [DW-1:0] nn_data;
    logic          nn_valid;
    logic [CW-1:0] nn_result;
    logic          nn_result_valid;
    logic          busy;
    logic          err_frame;
    logic          err_timeout;

    always #5 aclk = ~aclk;

    nn_infer_sched_if #(.DATA_WIDTH(DW), .CLASS_WIDTH(CW)) hif ();

    nn_infer_sched #(
        .DATA_WIDTH     (DW),
        .NUM_INPUTS     (NI),
        .CLASS_WIDTH    (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk            (aclk),
        .reset           (reset),
        .host            (hif),
        .nn_data         (nn_data),
        .nn_valid        (nn_valid),
        .nn_result       (nn_result),
        .nn_result_valid (nn_result_valid),
        .busy            (busy),
        .err_frame       (err_frame),
        .err_timeout     (err_timeout)
    );

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int tests    = 0;
    int failures = 0;
    int wait_e   = 0;

    logic [DW-1:0] nn_data_q[$];
    int            nn_cyc_q[$];
    int            ef_cyc_q[$];
    int            to_cyc_q[$];
    logic [CW-1:0] res_class_q[$];
    int            res_cyc_q[$];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cyc, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Monitor: compares every output event against the scoreboard queues.
    logic          prev_reset   = 1'b1;
    logic          prev_m_valid = 1'b0;
    logic          prev_m_ready = 1'b0;
    logic [CW-1:0] held_class   = '0;

    always @(negedge aclk) begin
        if (prev_reset) begin
            checkOutput("rst_nn_valid", nn_valid, 0);
            checkOutput("rst_nn_data", nn_data, 0);
            checkOutput("rst_m_valid", hif.m_valid, 0);
            checkOutput("rst_m_class", hif.m_class, 0);
            checkOutput("rst_err_frame", err_frame, 0);
            checkOutput("rst_err_timeout", err_timeout, 0);
            checkOutput("rst_busy", busy, 0);
        end else begin
            if (nn_valid) begin
                if (nn_data_q.size() == 0) begin
                    checkOutput("nn_valid_unexpected", nn_valid, 0);
                end else begin
                    logic [DW-1:0] d;
                    int            c;
                    d = nn_data_q.pop_front();
                    c = nn_cyc_q.pop_front();
                    checkOutput("nn_data", nn_data, d);
                    checkOutput("nn_valid_cycle", cyc, c);
                end
            end
            if (err_frame) begin
                if (ef_cyc_q.size() == 0) checkOutput("err_frame_unexpected", err_frame, 0);
                else checkOutput("err_frame_cycle", cyc, ef_cyc_q.pop_front());
            end
            if (err_timeout) begin
                if (to_cyc_q.size() == 0) checkOutput("err_timeout_unexpected", err_timeout, 0);
                else checkOutput("err_timeout_cycle", cyc, to_cyc_q.pop_front());
            end
            if (hif.m_valid) begin
                if (prev_m_valid && prev_m_ready) begin
                    checkOutput("m_valid_drop", hif.m_valid, 0);
                end else if (!prev_m_valid) begin
                    if (res_class_q.size() == 0) begin
                        checkOutput("m_valid_unexpected", hif.m_valid, 0);
                    end else begin
                        logic [CW-1:0] k;
                        int            c;
                        k = res_class_q.pop_front();
                        c = res_cyc_q.pop_front();
                        checkOutput("m_class", hif.m_class, k);
                        checkOutput("m_valid_cycle", cyc, c);
                    end
                    held_class = hif.m_class;
                end else begin
                    checkOutput("m_class_stable", hif.m_class, held_class);
                end
            end else if (prev_m_valid && !prev_m_ready) begin
                checkOutput("m_valid_hold", hif.m_valid, 1);
            end
        end
        prev_reset   = reset;
        prev_m_valid = hif.m_valid;
        prev_m_ready = hif.m_ready;
    end

    // Sends one frame of NI beats. Bit b-1 of last_mask puts s_last on beat b.
    // A frame error is expected on every beat whose s_last disagrees with
    // "this is beat NI". Optional idle gaps and ignored result noise.
    task automatic applyStimulus(input int last_mask, input int max_gap, input bit noise);
        for (int b = 1; b <= NI; b++) begin
            int            gap;
            logic [DW-1:0] d;
            bit            lst;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                hif.s_valid     = 1'b0;
                hif.s_last      = 1'($urandom);
                hif.s_data      = DW'($urandom);
                nn_result_valid = noise ? 1'($urandom) : 1'b0;
                nn_result       = $urandom;
                checkOutput("s_ready_load", hif.s_ready, 1);
                checkOutput("busy_load", busy, (b > 1));
                step();
            end
            d   = DW'($urandom);
            lst = ((last_mask >> (b - 1)) & 1) != 0;
            hif.s_valid     = 1'b1;
            hif.s_data      = d;
            hif.s_last      = lst;
            nn_result_valid = noise ? 1'($urandom) : 1'b0;
            nn_result       = $urandom;
            checkOutput("s_ready_load", hif.s_ready, 1);
            checkOutput("busy_load", busy, (b > 1));
            nn_data_q.push_back(d);
            nn_cyc_q.push_back(cyc + 1);
            if (lst != (b == NI)) ef_cyc_q.push_back(cyc + 1);
            step();
        end
        hif.s_valid     = 1'b0;
        hif.s_last      = 1'b0;
        nn_result_valid = 1'b0;
        wait_e = cyc;
        checkOutput("s_ready_wait", hif.s_ready, 0);
        checkOutput("busy_wait", busy, 1);
    endtask

    // Presents the result 'delay' cycles into WAIT (delay >= TO means the
    // watchdog fires first; delay == TO also drives a late, ignored result),
    // then holds m_ready low for 'hold' cycles before consuming it.
    task automatic deliverResult(input int delay, input int hold,
                                 input logic [CW-1:0] cls, input bit junk);
        int k = 0;
        while (k < delay && k < TO) begin
            hif.s_valid = junk ? 1'($urandom) : 1'b0;
            hif.s_data  = DW'($urandom);
            hif.s_last  = 1'($urandom);
            checkOutput("s_ready_wait", hif.s_ready, 0);
            checkOutput("busy_wait", busy, 1);
            step();
            k++;
        end
        hif.s_valid = 1'b0;
        hif.s_last  = 1'b0;
        if (delay >= TO) begin
            to_cyc_q.push_back(wait_e + TO);
            nn_result_valid = (delay == TO);
            nn_result       = cls;
            checkOutput("s_ready_after_timeout", hif.s_ready, 1);
            checkOutput("busy_after_timeout", busy, 0);
            step();
            nn_result_valid = 1'b0;
        end else begin
            nn_result_valid = 1'b1;
            nn_result       = cls;
            hif.m_ready     = (hold == 0);
            hif.s_valid     = junk ? 1'($urandom) : 1'b0;
            res_class_q.push_back(cls);
            res_cyc_q.push_back(cyc + 1);
            step();
            nn_result_valid = 1'b0;
            for (int h = 0; h < hold; h++) begin
                hif.m_ready     = 1'b0;
                hif.s_valid     = junk ? 1'($urandom) : 1'b0;
                hif.s_data      = DW'($urandom);
                nn_result_valid = junk ? 1'($urandom) : 1'b0;
                nn_result       = $urandom;
                checkOutput("s_ready_result", hif.s_ready, 0);
                checkOutput("busy_result", busy, 1);
                step();
            end
            hif.m_ready     = 1'b1;
            hif.s_valid     = 1'b0;
            nn_result_valid = 1'b0;
            step();
            hif.m_ready = 1'b0;
            checkOutput("s_ready_idle", hif.s_ready, 1);
            checkOutput("busy_idle", busy, 0);
        end
    endtask

    // Two beats of a frame, then reset with a third beat on the bus; that
    // beat must not be forwarded.
    task automatic resetMidLoad();
        for (int b = 1; b <= 2; b++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            hif.s_valid = 1'b1;
            hif.s_data  = d;
            hif.s_last  = 1'b0;
            nn_data_q.push_back(d);
            nn_cyc_q.push_back(cyc + 1);
            step();
        end
        reset       = 1'b1;
        hif.s_data  = DW'($urandom);
        step();
        reset       = 1'b0;
        hif.s_valid = 1'b0;
        checkOutput("nn_valid_after_reset", nn_valid, 0);
        checkOutput("s_ready_after_reset", hif.s_ready, 1);
        checkOutput("busy_after_reset", busy, 0);
    endtask

    // Captures a result, leaves it pending, then resets: it must vanish.
    task automatic resetInResult();
        applyStimulus(1 << (NI - 1), 0, 0);
        nn_result_valid = 1'b1;
        nn_result       = 32'hDEAD_BEEF;
        hif.m_ready     = 1'b0;
        res_class_q.push_back(32'hDEAD_BEEF);
        res_cyc_q.push_back(cyc + 1);
        step();
        nn_result_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("m_valid_after_reset", hif.m_valid, 0);
        checkOutput("m_class_after_reset", hif.m_class, 0);
        checkOutput("busy_after_reset", busy, 0);
    endtask

    initial begin
        reset           = 1'b1;
        hif.s_valid     = 1'b0;
        hif.s_data      = '0;
        hif.s_last      = 1'b0;
        hif.m_ready     = 1'b0;
        nn_result       = '0;
        nn_result_valid = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        checkOutput("s_ready_idle_reset", hif.s_ready, 1);
        step();

        // Clean frame, result 10 cycles into WAIT, consumer always ready.
        applyStimulus(1 << (NI - 1), 0, 0);
        deliverResult(10, 0, 32'd7, 0);
        // s_last on beats 2 and NI: exactly one frame error (beat 2).
        applyStimulus((1 << 1) | (1 << (NI - 1)), 0, 0);
        deliverResult(5, 0, 32'd3, 0);
        // No s_last at all: error on the final beat.
        applyStimulus(0, 1, 0);
        deliverResult(2, 1, 32'd9, 0);
        // Watchdog expiry, then a late result in the first IDLE cycle.
        applyStimulus(1 << (NI - 1), 0, 0);
        deliverResult(TO, 0, 32'd11, 0);
        // Plain timeout, no result at all.
        applyStimulus(1 << (NI - 1), 0, 0);
        deliverResult(TO + 3, 0, 32'd12, 1);
        // Result in the expiry cycle wins.
        applyStimulus(1 << (NI - 1), 0, 0);
        deliverResult(TO - 1, 0, 32'h1234_5678, 0);
        // Result held 15 cycles while the source keeps pushing.
        applyStimulus(1 << (NI - 1), 0, 0);
        deliverResult(0, 15, 32'hCAFE_0001, 1);
        // Reset mid-frame, then a fresh frame completes normally.
        resetMidLoad();
        applyStimulus(1 << (NI - 1), 0, 0);
        deliverResult(4, 0, 32'd5, 0);
        resetInResult();
        applyStimulus(1 << (NI - 1), 2, 1);
        deliverResult(1, 2, 32'd8, 1);

        for (int i = 0; i < 30; i++) begin
            int mask;
            mask = ($urandom_range(3, 0) == 0) ? int'($urandom_range((1 << NI) - 1, 0))
                                               : (1 << (NI - 1));
            applyStimulus(mask, 3, 1);
            deliverResult(int'($urandom_range(TO + 1, 0)), int'($urandom_range(5, 0)),
                          $urandom, 1);
        end

        repeat (3) step();
        checkOutput("nn_queue_drained", nn_data_q.size(), 0);
        checkOutput("err_frame_queue_drained", ef_cyc_q.size(), 0);
        checkOutput("err_timeout_queue_drained", to_cyc_q.size(), 0);
        checkOutput("result_queue_drained", res_class_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation still running at cycle %0d, limit 200000", cyc);
        $fatal(1);
    end

endmodule

// File: doc/nn_infer_sched.md
Name: nn_infer_sched

Overview:
Inference scheduler that sits in front of the layer chain and owns one complete inference transaction. It accepts a framed input stream with a valid/ready handshake and forwards exactly NUM_INPUTS samples to layer 1 as a valid-only stream. It then blocks new input until the max-finder reports a class, or until a watchdog expires. The captured class is presented on a valid/ready result port, so software or a DMA never overruns the handshake-free layer pipeline.

Parameters:
DATA_WIDTH, 16, width of one input sample (matches network data width)
NUM_INPUTS, 784, samples per inference (equals layer-1 weight count); must be >= 2
CLASS_WIDTH, 32, width of max-finder result
TIMEOUT_CYCLES, 65535, WAIT-state watchdog limit; must be >= 1

Ports:
aclk  in  1  clock
reset  in  1  synchronous, active-high reset
s_data  in  DATA_WIDTH  input sample
s_valid  in  1  sample valid
s_last  in  1  marks final sample of a frame
s_ready  out  1  scheduler can accept a sample
nn_data  out  DATA_WIDTH  sample to layer 1
nn_valid  out  1  one-cycle qualifier for nn_data
nn_result  in  CLASS_WIDTH  max-finder output
nn_result_valid  in  1  max-finder output valid (pulse)
m_class  out  CLASS_WIDTH  captured class
m_valid  out  1  result available
m_ready  in  1  result consumer ready
busy  out  1  high in any state other than IDLE
err_frame  out  1  one-cycle pulse: s_last misplaced
err_timeout  out  1  one-cycle pulse: watchdog expired

Behaviour:
- Clock aclk; reset is synchronous, active-high.
- Reset values: state=IDLE, beat count=0, timer=0, nn_valid=0, nn_data=0, m_valid=0, m_class=0, err_frame=0, err_timeout=0, busy=0.
- Reset asserted mid-operation aborts the transaction immediately:
  - no further nn_valid is issued;
  - a pending result is discarded.
- States: IDLE, LOAD, WAIT, RESULT.
- s_ready=1 only in IDLE and LOAD. It is combinational from state.
- Beat accept = s_valid && s_ready.
- IDLE: an accepted beat sets count=1 and moves to LOAD.
- LOAD: each accepted beat increments count. The beat that is sample NUM_INPUTS moves to WAIT; s_ready drops the next cycle.
- Every accepted beat is registered: nn_data=s_data and nn_valid=1 on the following cycle (latency 1). nn_valid is 0 otherwise. No gaps are inserted; idle input cycles give nn_valid=0.
- Framing: the sample count alone governs state transitions.
  - err_frame pulses (cycle after accept) if s_last=1 on any beat other than beat NUM_INPUTS.
  - err_frame also pulses if s_last=0 on beat NUM_INPUTS.
  - The frame is never truncated or extended.
- WAIT: the timer increments each cycle from 0.
  - nn_result_valid=1 captures m_class=nn_result, sets m_valid=1 next cycle, and moves to RESULT.
  - If the timer reaches TIMEOUT_CYCLES without a result: err_timeout pulses, the state returns to IDLE, and m_valid stays 0.
  - nn_result_valid and timer expiry in the same cycle: the result wins, and err_timeout does not pulse.
- RESULT: m_class and m_valid are held stable until m_valid && m_ready. Then m_valid drops next cycle and the state returns to IDLE.
  - s_ready stays 0 in RESULT (single result slot, no overlap).
- nn_result_valid in IDLE, LOAD or RESULT is ignored: no capture and no error.
- Counter widths: count is $clog2(NUM_INPUTS+1) bits; timer is $clog2(TIMEOUT_CYCLES+1) bits; neither wraps.

Optional Feature:
NN_SCHED_PERF_EN
- Defined:
  - Adds output perf_latency [31:0]: cycles from the first accepted beat to result capture, latched on capture. Reset value 0; the value from a timed-out transaction is not latched.
  - Adds output perf_frames [31:0]: count of completed (result-delivered) inferences. Reset value 0; wraps at 2^32.
- Not defined: both ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package nn_sched_pkg:
  - state enum (IDLE/LOAD/WAIT/RESULT);
  - width helper constants COUNT_W and TIMER_W derived via $clog2.
- One natural sub-module: nn_sched_watchdog. It holds the loadable timer with clear/enable/expired, parameterised by TIMEOUT_CYCLES.
- Everything else stays in the top FSM.

Test Plan:
- NUM_INPUTS=4; stream 4 beats back-to-back with s_last on beat 4; drive nn_result=7 ten cycles later; m_ready=1 -> 4 nn_valid pulses, each 1 cycle after its accept; m_class=7, m_valid for 1 cycle; err_frame=0; busy returns to 0.
- Same stream with s_last on beat 2 -> err_frame pulses once; all 4 beats are still forwarded; state still reaches WAIT.
- TIMEOUT_CYCLES=20; send a frame and withhold nn_result_valid -> err_timeout pulses 20 cycles into WAIT; s_ready returns to 1; m_valid stays 0.
- nn_result_valid coincident with the expiry cycle -> result is captured; no err_timeout.
- Result held with m_ready=0 for 15 cycles, while the source drives s_valid=1 -> s_ready=0 throughout; m_class is stable; no nn_valid; after m_ready=1 the next frame is accepted.
- Assert reset during LOAD after beat 2 -> nn_valid=0 the next cycle; all outputs at reset values; a fresh 4-beat frame then completes normally.
